segment_frame_driver: RTL and testbench

Downstream stage of the four-digit time-division scan. Consumes the rotating active-low digit select and a 16-bit hex value, and drives the common-cathode seven-segment display with a segment pattern aligned to the enabled digit. New values are accepted via a ready/load handshake and committed only at a frame boundary, so a frame never mixes old and new digits.

---
 rtl/segment_frame_driver_pkg.sv | 14 +
 rtl/segment_frame_driver_font.sv | 11 +
 rtl/segment_frame_driver.sv | 121 ++++++++++++
 tb/tb_segment_frame_driver.sv | 126 ++++++++++++
 4 files changed

// File: rtl/segment_frame_driver_pkg.sv
// Shared constants for the seven-segment frame driver: font table and select codes.
package segment_frame_driver_pkg;

    localparam logic [3:0] SEL_FRAME_START = 4'b0111;
    localparam logic [3:0] SEL_OFF         = 4'b1111;
    localparam logic [6:0] SEG_BLANK       = 7'b0;

    // {g,f,e,d,c,b,a}; entry 15 first so FONT[n] is the glyph for nibble n
    localparam logic [15:0][6:0] FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/segment_frame_driver_font.sv
// hex_segment_font: combinational nibble to seven-segment glyph lookup.
module hex_segment_font
    import segment_frame_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = FONT[nibble_i];

endmodule

// File: rtl/segment_frame_driver.sv
// Latches hex value/dots via ready/load, commits at frame start, drives aligned digit/segment outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module segment_frame_driver
    import segment_frame_driver_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [3:0]  select_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dots_i,
    input  logic        load_i,
    output logic        ready_o,
    output logic [3:0]  digit_n_o,
    output logic [6:0]  segments_o,
    output logic        dp_o
);

    logic [3:0]  prev_sel_q;
    logic        ready_q, ready_d;
    logic [15:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [3:0]  pend_dots_q, pend_dots_d, disp_dots_q, disp_dots_d;
    logic [3:0]  digit_n_q, digit_n_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic        frame_start, accept;
    logic        sel_valid, blank;
    logic [1:0]  idx;
    logic [3:0]  nibble;
    logic [6:0]  font_seg;

    assign frame_start = (select_i == SEL_FRAME_START) && (prev_sel_q != SEL_FRAME_START);
    assign accept      = load_i && ready_q;

    always_comb begin
        ready_d     = ready_q;
        pend_val_d  = pend_val_q;
        pend_dots_d = pend_dots_q;
        disp_val_d  = disp_val_q;
        disp_dots_d = disp_dots_q;
        if (accept && frame_start) begin
            disp_val_d  = value_i;
            disp_dots_d = dots_i;
        end else if (accept) begin
            pend_val_d  = value_i;
            pend_dots_d = dots_i;
            ready_d     = 1'b0;
        end else if (frame_start && !ready_q) begin
            disp_val_d  = pend_val_q;
            disp_dots_d = pend_dots_q;
            ready_d     = 1'b1;
        end
    end

    always_comb begin
        sel_valid = 1'b1;
        idx       = 2'd0;
        case (select_i)
            4'b0111: idx = 2'd3;
            4'b1011: idx = 2'd2;
            4'b1101: idx = 2'd1;
            4'b1110: idx = 2'd0;
            default: sel_valid = 1'b0;
        endcase
    end

    // Look up from the next display value so the committing frame's first digit is already new
    assign nibble = disp_val_d[{idx, 2'b00} +: 4];

    hex_segment_font u_font (
        .nibble_i (nibble),
        .seg_o    (font_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = (idx != 2'd0) && ((disp_val_d >> {idx, 2'b00}) == 16'h0000);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        digit_n_d = SEL_OFF;
        seg_d     = SEG_BLANK;
        dp_d      = 1'b0;
        if (sel_valid) begin
            digit_n_d = select_i;
            seg_d     = blank ? SEG_BLANK : font_seg;
            dp_d      = disp_dots_d[idx];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            prev_sel_q  <= SEL_OFF;
            ready_q     <= 1'b1;
            pend_val_q  <= '0;
            pend_dots_q <= '0;
            disp_val_q  <= '0;
            disp_dots_q <= '0;
            digit_n_q   <= SEL_OFF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b0;
        end else begin
            prev_sel_q  <= select_i;
            ready_q     <= ready_d;
            pend_val_q  <= pend_val_d;
            pend_dots_q <= pend_dots_d;
            disp_val_q  <= disp_val_d;
            disp_dots_q <= disp_dots_d;
            digit_n_q   <= digit_n_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign ready_o    = ready_q;
    assign digit_n_o  = digit_n_q;
    assign segments_o = seg_q;
    assign dp_o       = dp_q;

endmodule

// File: tb/tb_segment_frame_driver.sv
// Directed self-checking bench for segment_frame_driver.
module tb_segment_frame_driver;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [3:0]  select_i;
    logic [15:0] value_i;
    logic [3:0]  dots_i;
    logic        load_i;
    logic        ready_o;
    logic [3:0]  digit_n_o;
    logic [6:0]  segments_o;
    logic        dp_o;

    int checks = 0;
    int errors = 0;

    segment_frame_driver dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .select_i   (select_i),
        .value_i    (value_i),
        .dots_i     (dots_i),
        .load_i     (load_i),
        .ready_o    (ready_o),
        .digit_n_o  (digit_n_o),
        .segments_o (segments_o),
        .dp_o       (dp_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs, then advance one clock and settle past the edge
    task automatic cyc(input logic [3:0] sel, input logic ld, input logic [15:0] val, input logic [3:0] dt);
        select_i = sel;
        load_i   = ld;
        value_i  = val;
        dots_i   = dt;
        @(posedge clock_i);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] dn, input logic [6:0] seg,
                              input logic dp, input logic rdy);
        check({tag, ".digit_n"}, {12'h0, digit_n_o}, {12'h0, dn});
        check({tag, ".seg"},     {9'h0, segments_o}, {9'h0, seg});
        check({tag, ".dp"},      {15'h0, dp_o},      {15'h0, dp});
        check({tag, ".ready"},   {15'h0, ready_o},   {15'h0, rdy});
    endtask

    initial begin
        reset_i = 1'b1;
        cyc(4'b0111, 1'b0, 16'h0, 4'h0);
        expect_out("rst0", 4'hF, 7'h00, 1'b0, 1'b1);
        cyc(4'b1011, 1'b1, 16'h9999, 4'hF);
        expect_out("rst1", 4'hF, 7'h00, 1'b0, 1'b1);
        #2 reset_i = 1'b0;

        // Cleared display shows zeros
        cyc(4'b0111, 1'b0, 16'h0, 4'h0); expect_out("zero3", 4'b0111, 7'h3F, 1'b0, 1'b1);
        cyc(4'b1011, 1'b0, 16'h0, 4'h0); expect_out("zero2", 4'b1011, 7'h3F, 1'b0, 1'b1);
        cyc(4'b1101, 1'b0, 16'h0, 4'h0); expect_out("zero1", 4'b1101, 7'h3F, 1'b0, 1'b1);
        cyc(4'b1110, 1'b0, 16'h0, 4'h0); expect_out("zero0", 4'b1110, 7'h3F, 1'b0, 1'b1);

        // Mid-frame load of 1234, second load ignored while pending
        cyc(4'b0111, 1'b0, 16'h0, 4'h0);     expect_out("mid3",  4'b0111, 7'h3F, 1'b0, 1'b1);
        cyc(4'b1011, 1'b1, 16'h1234, 4'h1);  expect_out("mid2",  4'b1011, 7'h3F, 1'b0, 1'b0);
        cyc(4'b1101, 1'b1, 16'hFFFF, 4'hF);  expect_out("mid1",  4'b1101, 7'h3F, 1'b0, 1'b0);
        cyc(4'b1110, 1'b0, 16'h0, 4'h0);     expect_out("mid0",  4'b1110, 7'h3F, 1'b0, 1'b0);
        cyc(4'b0111, 1'b0, 16'h0, 4'h0);     expect_out("c1234_3", 4'b0111, 7'h06, 1'b0, 1'b1);
        cyc(4'b1011, 1'b0, 16'h0, 4'h0);     expect_out("c1234_2", 4'b1011, 7'h5B, 1'b0, 1'b1);
        cyc(4'b1101, 1'b0, 16'h0, 4'h0);     expect_out("c1234_1", 4'b1101, 7'h4F, 1'b0, 1'b1);
        cyc(4'b1110, 1'b0, 16'h0, 4'h0);     expect_out("c1234_0", 4'b1110, 7'h66, 1'b1, 1'b1);

        // Load coinciding with frame start goes straight to display
        cyc(4'b0111, 1'b1, 16'hABCD, 4'h0);  expect_out("abcd3", 4'b0111, 7'h77, 1'b0, 1'b1);
        cyc(4'b1011, 1'b0, 16'h0, 4'h0);     expect_out("abcd2", 4'b1011, 7'h7C, 1'b0, 1'b1);
        cyc(4'b1101, 1'b0, 16'h0, 4'h0);     expect_out("abcd1", 4'b1101, 7'h39, 1'b0, 1'b1);
        cyc(4'b1110, 1'b0, 16'h0, 4'h0);     expect_out("abcd0", 4'b1110, 7'h5E, 1'b0, 1'b1);

        // Invalid selects blank; held 0111 does not retrigger frame start
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0011, 1'b0, 16'h0, 4'h0); expect_out("inv0011", 4'hF, 7'h00, 1'b0, 1'b1);
        end
        cyc(4'b0111, 1'b0, 16'h0, 4'h0);     expect_out("hold3a", 4'b0111, 7'h77, 1'b0, 1'b1);
        cyc(4'b0111, 1'b1, 16'h0070, 4'h0);  expect_out("hold3b", 4'b0111, 7'h77, 1'b0, 1'b0);
        cyc(4'b1011, 1'b0, 16'h0, 4'h0);     expect_out("hold2",  4'b1011, 7'h7C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 1'b0, 16'h0, 4'h0); expect_out("inv1111", 4'hF, 7'h00, 1'b0, 1'b0);
        end

        // Commit 0070 after the off period
`ifdef LEADING_ZERO_BLANK_EN
        cyc(4'b0111, 1'b0, 16'h0, 4'h0);     expect_out("z70_3", 4'b0111, 7'h00, 1'b0, 1'b1);
        cyc(4'b1011, 1'b0, 16'h0, 4'h0);     expect_out("z70_2", 4'b1011, 7'h00, 1'b0, 1'b1);
`else
        cyc(4'b0111, 1'b0, 16'h0, 4'h0);     expect_out("z70_3", 4'b0111, 7'h3F, 1'b0, 1'b1);
        cyc(4'b1011, 1'b0, 16'h0, 4'h0);     expect_out("z70_2", 4'b1011, 7'h3F, 1'b0, 1'b1);
`endif
        cyc(4'b1101, 1'b0, 16'h0, 4'h0);     expect_out("z70_1", 4'b1101, 7'h07, 1'b0, 1'b1);
        cyc(4'b1110, 1'b0, 16'h0, 4'h0);     expect_out("z70_0", 4'b1110, 7'h3F, 1'b0, 1'b1);

        // Reset mid-handshake blanks immediately and drops the pending load
        cyc(4'b0111, 1'b0, 16'h0, 4'h0);
        cyc(4'b1011, 1'b1, 16'h5555, 4'hF);  expect_out("prerst", 4'b1011, 7'h3F, 1'b0, 1'b0);
        #2 reset_i = 1'b1;
        #1 expect_out("asyncrst", 4'hF, 7'h00, 1'b0, 1'b1);
        #3 reset_i = 1'b0;
        cyc(4'b1101, 1'b0, 16'h0, 4'h0);     expect_out("post1", 4'b1101, 7'h3F, 1'b0, 1'b1);
        cyc(4'b1110, 1'b0, 16'h0, 4'h0);     expect_out("post0", 4'b1110, 7'h3F, 1'b0, 1'b1);
        cyc(4'b0111, 1'b0, 16'h0, 4'h0);     expect_out("post3", 4'b0111, 7'h3F, 1'b0, 1'b1);
        cyc(4'b1011, 1'b0, 16'h0, 4'h0);     expect_out("post2", 4'b1011, 7'h3F, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
